mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: on a tie the requester that did not win last is chosen.
module rr_arb2 (
  input  logic       reqA_i,
  input  logic       reqB_i,
  input  logic       lastWinner_i,
  output logic [1:0] grant_o,
  output logic       winner_o
);
  import mem_arbiter_pkg::*;

  always_comb begin
    grant_o  = 2'b00;
    winner_o = REQ_A;
    if (reqA_i && reqB_i) begin
      winner_o = ~lastWinner_i;
    end else if (reqB_i) begin
      winner_o = REQ_B;
    end
    if (reqA_i || reqB_i) begin
      grant_o = (winner_o == REQ_A) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port (A) and a loader port (B) onto one data memory with
// a fixed IDLE -> ISSUE -> RESP sequence per access.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_a_req,
  input  logic              in_a_we,
  input  logic [ADDR_W-1:0] in_a_addr,
  input  logic [DATA_W-1:0] in_a_wdata,
  input  logic              in_b_req,
  input  logic              in_b_we,
  input  logic [ADDR_W-1:0] in_b_addr,
  input  logic [DATA_W-1:0] in_b_wdata,
  output logic              out_a_ack,
  output logic [DATA_W-1:0] out_a_rdata,
  output logic              out_b_ack,
  output logic [DATA_W-1:0] out_b_rdata,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata
);
  import mem_arbiter_pkg::*;

  state_e            state_q, state_d;
  logic              winner_q, winner_d;
  logic              lastWinner_q, lastWinner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdataA_q, rdataA_d;
  logic [DATA_W-1:0] rdataB_q, rdataB_d;

  logic [1:0]        grant;
  logic              winId;

  rr_arb2 uArb (
    .reqA_i       (in_a_req),
    .reqB_i       (in_b_req),
    .lastWinner_i (lastWinner_q),
    .grant_o      (grant),
    .winner_o     (winId)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= REQ_A;
      lastWinner_q <= REQ_B;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdataA_q     <= '0;
      rdataB_q     <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      lastWinner_q <= lastWinner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdataA_q     <= rdataA_d;
      rdataB_q     <= rdataB_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    lastWinner_d = lastWinner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdataA_d     = rdataA_q;
    rdataB_d     = rdataB_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          winner_d = winId;
          we_d     = (winId == REQ_A) ? in_a_we    : in_b_we;
          addr_d   = (winId == REQ_A) ? in_a_addr  : in_b_addr;
          wdata_d  = (winId == REQ_A) ? in_a_wdata : in_b_wdata;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        lastWinner_d = winner_q;
        if (!we_q) begin
          if (winner_q == REQ_A) rdataA_d = in_mem_rdata;
          else                   rdataB_d = in_mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is passed through in the ack cycle and held in the register afterwards.
  assign out_a_ack     = (state_q == RESP) && (winner_q == REQ_A);
  assign out_b_ack     = (state_q == RESP) && (winner_q == REQ_B);
  assign out_a_rdata   = (out_a_ack && !we_q) ? in_mem_rdata : rdataA_q;
  assign out_b_rdata   = (out_b_ack && !we_q) ? in_mem_rdata : rdataB_q;
  assign out_mem_read  = (state_q == ISSUE) && !we_q;
  assign out_mem_write = (state_q == ISSUE) && we_q;
  assign out_mem_addr  = addr_q;
  assign out_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed vectors.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_a_req, in_a_we, in_b_req, in_b_we;
  logic [AW-1:0] in_a_addr, in_b_addr;
  logic [DW-1:0] in_a_wdata, in_b_wdata;
  logic          out_a_ack, out_b_ack, out_mem_read, out_mem_write;
  logic [DW-1:0] out_a_rdata, out_b_rdata, out_mem_wdata;
  logic [AW-1:0] out_mem_addr;
  logic [DW-1:0] in_mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_a_req      (in_a_req),
    .in_a_we       (in_a_we),
    .in_a_addr     (in_a_addr),
    .in_a_wdata    (in_a_wdata),
    .in_b_req      (in_b_req),
    .in_b_we       (in_b_we),
    .in_b_addr     (in_b_addr),
    .in_b_wdata    (in_b_wdata),
    .out_a_ack     (out_a_ack),
    .out_a_rdata   (out_a_rdata),
    .out_b_ack     (out_b_ack),
    .out_b_rdata   (out_b_rdata),
    .out_mem_read  (out_mem_read),
    .out_mem_write (out_mem_write),
    .out_mem_addr  (out_mem_addr),
    .out_mem_wdata (out_mem_wdata),
    .in_mem_rdata  (in_mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic aReq, input logic aWe, input logic [31:0] aAddr,
                               input logic [31:0] aWdata, input logic bReq, input logic bWe,
                               input logic [31:0] bAddr, input logic [31:0] bWdata);
    in_a_req = aReq; in_a_we = aWe; in_a_addr = aAddr; in_a_wdata = aWdata;
    in_b_req = bReq; in_b_we = bWe; in_b_addr = bAddr; in_b_wdata = bWdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory environment: unwritten words read back as their own (word-aligned) address.
  bit [31:0] memArr [0:255];
  bit        written [0:255];

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (written[a[9:2]]) return memArr[a[9:2]];
    return {22'd0, a[9:2], 2'b00};
  endfunction

  always @(posedge clk) begin
    if (out_mem_write) begin
      memArr[out_mem_addr[9:2]]  <= out_mem_wdata;
      written[out_mem_addr[9:2]] <= 1'b1;
    end
  end

  // Transaction model: a grant in free cycle N strobes memory in N+1 and acks in N+2.
  int          cyc = 0;
  int          grantCyc = 0;
  bit          busy = 1'b0;
  bit          started = 1'b0;
  logic        txWho, txWe, lastW;
  logic [31:0] txAddr, txWdata;
  logic [31:0] expRdA, expRdB, expAddr, expWdata;

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0; lastW = 1'b1;
      expRdA = '0; expRdB = '0; expAddr = '0; expWdata = '0;
    end else if (busy) begin
      if (cyc == grantCyc + 2) begin
        if (!txWe) begin
          if (txWho == 1'b0) expRdA = memRead(txAddr);
          else               expRdB = memRead(txAddr);
        end
        lastW = txWho;
        busy  = 1'b0;
      end
    end else if (in_a_req || in_b_req) begin
      txWho    = (in_a_req && in_b_req) ? ~lastW : (in_a_req ? 1'b0 : 1'b1);
      txWe     = txWho ? in_b_we    : in_a_we;
      txAddr   = txWho ? in_b_addr  : in_a_addr;
      txWdata  = txWho ? in_b_wdata : in_a_wdata;
      grantCyc = cyc;
      busy     = 1'b1;
      expAddr  = txAddr;
      expWdata = txWdata;
    end
    cyc++;
    started = 1'b1;
  end

  // Every-cycle comparison against the model, then present memory read data for the new address.
  logic        issueNow, respNow, eAckA, eAckB;
  logic [31:0] eRdA, eRdB;

  always @(negedge clk) begin
    if (started) begin
      issueNow = busy && (cyc == grantCyc + 1);
      respNow  = busy && (cyc == grantCyc + 2);
      eAckA    = respNow && (txWho == 1'b0);
      eAckB    = respNow && (txWho == 1'b1);
      eRdA     = (eAckA && !txWe) ? memRead(txAddr) : expRdA;
      eRdB     = (eAckB && !txWe) ? memRead(txAddr) : expRdB;
      checkOutput("model a_ack",     32'(out_a_ack),     32'(eAckA));
      checkOutput("model b_ack",     32'(out_b_ack),     32'(eAckB));
      checkOutput("model mem_read",  32'(out_mem_read),  32'(issueNow && !txWe));
      checkOutput("model mem_write", 32'(out_mem_write), 32'(issueNow && txWe));
      checkOutput("model mem_addr",  out_mem_addr,  expAddr);
      checkOutput("model mem_wdata", out_mem_wdata, expWdata);
      checkOutput("model a_rdata",   out_a_rdata,   eRdA);
      checkOutput("model b_rdata",   out_b_rdata,   eRdB);
      checkOutput("both acks",       32'(out_a_ack && out_b_ack),         32'd0);
      checkOutput("both strobes",    32'(out_mem_read && out_mem_write),  32'd0);
      checkOutput("strobe off-issue", 32'((out_mem_read || out_mem_write) && !issueNow), 32'd0);
    end
    in_mem_rdata = memRead(out_mem_addr);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset a_ack",   32'(out_a_ack),    32'd0);
    checkOutput("reset read",    32'(out_mem_read), 32'd0);
    checkOutput("reset addr",    out_mem_addr,  32'd0);
    checkOutput("reset wdata",   out_mem_wdata, 32'd0);
    checkOutput("reset a_rdata", out_a_rdata,   32'd0);
    checkOutput("reset b_rdata", out_b_rdata,   32'd0);

    $display("[TB] A read 0x100");
    tick(); applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("t1 N no ack",   32'(out_a_ack),    32'd0);
    @(negedge clk); checkOutput("t1 N+1 read",   32'(out_mem_read), 32'd1);
                    checkOutput("t1 N+1 addr",   out_mem_addr,      32'h100);
    @(negedge clk); checkOutput("t1 N+2 ack",    32'(out_a_ack),    32'd1);
                    checkOutput("t1 N+2 rdata",  out_a_rdata,       32'h100);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] B write 0x80");
    tick(); applyStimulus(0, 0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF);
    @(negedge clk); checkOutput("t2 N no ack",   32'(out_b_ack),     32'd0);
    @(negedge clk); checkOutput("t2 N+1 write",  32'(out_mem_write), 32'd1);
                    checkOutput("t2 N+1 addr",   out_mem_addr,       32'h80);
                    checkOutput("t2 N+1 wdata",  out_mem_wdata,      32'hDEADBEEF);
    @(negedge clk); checkOutput("t2 N+2 ack",    32'(out_b_ack),     32'd1);
                    checkOutput("t2 b_rdata",    out_b_rdata,        32'd0);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("t2 write low",  32'(out_mem_write), 32'd0);
                    checkOutput("t2 addr hold",  out_mem_addr,       32'h80);

    $display("[TB] B read back 0x80");
    tick(); applyStimulus(0, 0, 0, 0, 1, 0, 32'h80, 0);
    repeat (3) @(negedge clk);
    checkOutput("t2b ack",   32'(out_b_ack), 32'd1);
    checkOutput("t2b rdata", out_b_rdata,    32'hDEADBEEF);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] A write keeps rdata");
    tick(); applyStimulus(1, 1, 32'h200, 32'hCAFE0001, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("t4w ack",   32'(out_a_ack), 32'd1);
    checkOutput("t4w rdata", out_a_rdata,    32'h100);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] dropped requests");
    tick(); applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0);
    tick(); applyStimulus(0, 0, 0, 0, 1, 0, 32'h44, 0);
    tick();
    @(negedge clk); checkOutput("t5 granted drop ack", 32'(out_a_ack), 32'd1);
                    checkOutput("t5 rdata",            out_a_rdata,    32'h40);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checkOutput("t5 ungranted b_ack", 32'(out_b_ack), 32'd0);
    end

    $display("[TB] simultaneous A/B from reset");
    rst = 1'b1;
    applyStimulus(1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h1234);
    tick(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("t3 a_ack order", 32'(out_a_ack), 32'((i == 2) || (i == 8)));
      checkOutput("t3 b_ack order", 32'(out_b_ack), 32'((i == 5) || (i == 11)));
      if (i == 2) checkOutput("t3 a_rdata", out_a_rdata, 32'h10);
    end
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] A alone, four accesses");
    tick(); applyStimulus(1, 0, 32'h84, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("t6 a_ack spacing", 32'(out_a_ack), 32'((i % 3) == 2));
      checkOutput("t6 b_ack never",   32'(out_b_ack), 32'd0);
    end
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset during ISSUE");
    tick(); applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk); checkOutput("t7 issue read", 32'(out_mem_read), 32'd1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t7 no ack",   32'(out_a_ack),     32'd0);
    checkOutput("t7 read",     32'(out_mem_read),  32'd0);
    checkOutput("t7 write",    32'(out_mem_write), 32'd0);
    checkOutput("t7 addr",     out_mem_addr,       32'd0);
    checkOutput("t7 wdata",    out_mem_wdata,      32'd0);
    checkOutput("t7 a_rdata",  out_a_rdata,        32'd0);
    checkOutput("t7 b_rdata",  out_b_rdata,        32'd0);
    tick(); rst = 1'b0;
    tick(); applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("t7 retry ack",   32'(out_a_ack), 32'd1);
    checkOutput("t7 retry rdata", out_a_rdata,    32'h300);
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
